slip_latch_bank_arbiter: RTL and testbench
==========================================

# slip_latch_bank_arbiter

Shared write controller for a small bank of D-type data latches in the Slipstream register area. Two requesters, CPU and DSP, issue level-held write requests. The block arbitrates them round-robin, sequences each write through a fixed grant, capture and acknowledge cycle, and drives the latch load strobes. Latch contents are readable asynchronously through a single read port.

## Interface
Parameters:
- ENTRIES, default 8: number of latch entries. Must equal 2**ADDR_W.
- ADDR_W, default 3: entry address width.
- WIDTH, default 8: data width per entry.

Ports:
- MasterClock  in  1  sole clock; all state updates on its rising edge.
- resetL  in  1  asynchronous, active-low reset.
- clrAll  in  1  synchronous clear of all entries; honoured only in IDLE.
- cpuReq  in  1  CPU write request, level; held until cpuAck.
- cpuAddr  in  ADDR_W  CPU target entry; stable while cpuReq is high.
- cpuData  in  WIDTH  CPU write data; stable while cpuReq is high.
- cpuAck  out  1  one-cycle completion pulse to CPU.
- dspReq, dspAddr, dspData, dspAck: same as the CPU set, for the DSP.
- rdAddr  in  ADDR_W  read select.
- rdData  out  WIDTH  entry[rdAddr], combinational.
- busy  out  1  high whenever state is not IDLE.

## Operation
- Storage: ENTRIES × WIDTH flops, all loaded on the MasterClock edge; no other clock.
- State machine: IDLE, CAPTURE, ACK.
- IDLE:
  - If clrAll=1, all entries are zeroed at this edge and state stays IDLE. Requests pending that cycle are not granted and remain pending.
  - Otherwise, eligible requests are arbitrated. The winner's addr and data are copied into holding registers, grantSel records the winner, and state goes to CAPTURE.
  - With no eligible request, state stays IDLE.
- Eligibility: a requester is eligible when req=1 and its armed flag is set.
  - The armed flag clears on that requester's ack cycle.
  - The armed flag sets again on any cycle where its req=0.
  - A req held high after ack therefore does not cause a second write.
- Arbitration: a single eligible requester wins. If both are eligible, the requester not named by lastGrant wins. lastGrant updates to the winner on the IDLE→CAPTURE transition.
- CAPTURE: load strobe for entry[holdAddr]; holdData is written at the end-of-cycle edge. State goes to ACK.
- ACK: the ack of grantSel is 1 for exactly this cycle. State goes to IDLE.
- A requester changing addr or data after grant does not affect the write, because the holding registers are used.
- rdData reflects a write starting in the ACK cycle.

## Timing
- Reset (resetL=0, async):
  - state=IDLE, busy=0, cpuAck=dspAck=0.
  - All entries = 0, so rdData=0.
  - Both armed flags = 1, lastGrant = DSP, so the CPU wins the first tie.
  - Holding registers = 0.
- Reset asserted mid-write aborts the write: the target entry reads 0 and no ack is issued. After resetL rises, operation resumes from IDLE on the next edge.
- Latency: req sampled high in IDLE at cycle n gives CAPTURE at n+1 and ACK at n+2.
  - ack=1 only in cycle n+2.
  - New data is visible on rdData in cycle n+2.
  - busy=1 in cycles n+1 and n+2.
- Throughput: one write per 3 cycles. Back-to-back grants are possible: IDLE at n+3 can grant the other requester.
- Simultaneous first-cycle requests from both: CPU acked at n+2. DSP granted at n+3 and acked at n+5.
- Same address from both: the later write wins the entry contents.
- clrAll and req in the same IDLE cycle: clear first. The request is granted the next cycle, so ack is one cycle later than normal.
- clrAll during CAPTURE or ACK is ignored.
- Address arithmetic: none. The address is used directly as the index, full range 0..ENTRIES-1, with no wrap handling needed.

## Test plan
- Reset then read: after resetL low→high, rdAddr swept 0..7 gives rdData=0x00 at every address. busy=0, acks=0.
- Single CPU write: cpuReq=1, cpuAddr=3, cpuData=0xA5 in cycle n.
  - cpuAck=1 only at n+2.
  - rdAddr=3 gives 0xA5 from n+2.
  - cpuReq held high to n+6 produces no second ack.
- Simultaneous requests: CPU (addr 1, 0x11) and DSP (addr 1, 0x22) both go high at n.
  - cpuAck at n+2, dspAck at n+5.
  - Entry 1 = 0x22 at the end.
  - Repeating the tie with re-armed requesters gives DSP first.
- Data change after grant: cpuData switched 0x55→0xFF at n+1 for a write to addr 0. Entry 0 = 0x55.
- clrAll collision: entries preloaded nonzero; clrAll=1 and dspReq (addr 7, 0x3C) both at n.
  - All entries = 0 after n.
  - dspAck at n+3.
  - Entry 7 = 0x3C.
- Reset mid-write: resetL pulsed low during CAPTURE of a write of 0x99 to addr 4.
  - No ack is issued.
  - Entry 4 = 0.
  - A new cpuReq after reset completes normally with ack 2 cycles later.

Source files
------------

// File: rtl/slip_latch_bank_arbiter.sv
// slip_latch_bank_arbiter
// Two-requester (CPU, DSP) round-robin write controller for a small latch bank.
// Each write goes IDLE (grant) -> CAPTURE (load strobe) -> ACK (one-cycle ack).
// Entries are read back combinationally through a single read port.
module slip_latch_bank_arbiter #(
    parameter int ENTRIES = 8,
    parameter int ADDR_W  = 3,
    parameter int WIDTH   = 8
) (
    input  logic              MasterClock,
    input  logic              resetL,
    input  logic              clrAll,
    input  logic              cpuReq,
    input  logic [ADDR_W-1:0] cpuAddr,
    input  logic [WIDTH-1:0]  cpuData,
    output logic              cpuAck,
    input  logic              dspReq,
    input  logic [ADDR_W-1:0] dspAddr,
    input  logic [WIDTH-1:0]  dspData,
    output logic              dspAck,
    input  logic [ADDR_W-1:0] rdAddr,
    output logic [WIDTH-1:0]  rdData,
    output logic              busy
);

    // Requester encoding used by grant_sel_r and last_grant_r
    localparam logic SEL_CPU = 1'b0;
    localparam logic SEL_DSP = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_ACK     = 2'd2
    } state_t;

    state_t              state_r;
    logic                busy_r;
    logic                cpu_ack_r;
    logic                dsp_ack_r;
    logic                grant_sel_r;
    logic                last_grant_r;
    logic [ADDR_W-1:0]   hold_addr_r;
    logic [WIDTH-1:0]    hold_data_r;
    logic                cpu_armed_r;
    logic                dsp_armed_r;
    logic [WIDTH-1:0]    entries_r [ENTRIES];

    logic                cpu_elig_s;
    logic                dsp_elig_s;
    logic                grant_valid_s;
    logic                grant_sel_s;

    assign cpu_elig_s = cpuReq & cpu_armed_r;
    assign dsp_elig_s = dspReq & dsp_armed_r;

    // Round-robin pick: on a tie the requester not named by last_grant_r wins
    always_comb begin
        grant_valid_s = 1'b0;
        grant_sel_s   = SEL_CPU;
        if (cpu_elig_s && dsp_elig_s) begin
            grant_valid_s = 1'b1;
            grant_sel_s   = (last_grant_r == SEL_DSP) ? SEL_CPU : SEL_DSP;
        end else if (cpu_elig_s) begin
            grant_valid_s = 1'b1;
            grant_sel_s   = SEL_CPU;
        end else if (dsp_elig_s) begin
            grant_valid_s = 1'b1;
            grant_sel_s   = SEL_DSP;
        end else begin
            grant_valid_s = 1'b0;
            grant_sel_s   = SEL_CPU;
        end
    end

    // Write sequencer: grant and latch holding registers, strobe, then ack
    always_ff @(posedge MasterClock or negedge resetL) begin
        if (!resetL) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            cpu_ack_r    <= 1'b0;
            dsp_ack_r    <= 1'b0;
            grant_sel_r  <= SEL_CPU;
            last_grant_r <= SEL_DSP;
            hold_addr_r  <= {ADDR_W{1'b0}};
            hold_data_r  <= {WIDTH{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    cpu_ack_r <= 1'b0;
                    dsp_ack_r <= 1'b0;
                    if (clrAll) begin
                        // Clear wins this cycle; pending requests wait
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end else if (grant_valid_s) begin
                        grant_sel_r  <= grant_sel_s;
                        last_grant_r <= grant_sel_s;
                        hold_addr_r  <= (grant_sel_s == SEL_DSP) ? dspAddr : cpuAddr;
                        hold_data_r  <= (grant_sel_s == SEL_DSP) ? dspData : cpuData;
                        state_r      <= ST_CAPTURE;
                        busy_r       <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                        busy_r  <= 1'b0;
                    end
                end
                ST_CAPTURE: begin
                    state_r   <= ST_ACK;
                    busy_r    <= 1'b1;
                    cpu_ack_r <= (grant_sel_r == SEL_CPU);
                    dsp_ack_r <= (grant_sel_r == SEL_DSP);
                end
                ST_ACK: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    cpu_ack_r <= 1'b0;
                    dsp_ack_r <= 1'b0;
                end
                default: begin
                    state_r   <= ST_IDLE;
                    busy_r    <= 1'b0;
                    cpu_ack_r <= 1'b0;
                    dsp_ack_r <= 1'b0;
                end
            endcase
        end
    end

    // Armed flags: drop on the requester's ack, re-arm whenever its req is low
    always_ff @(posedge MasterClock or negedge resetL) begin
        if (!resetL) begin
            cpu_armed_r <= 1'b1;
            dsp_armed_r <= 1'b1;
        end else begin
            if (!cpuReq) begin
                cpu_armed_r <= 1'b1;
            end else if (cpu_ack_r) begin
                cpu_armed_r <= 1'b0;
            end else begin
                cpu_armed_r <= cpu_armed_r;
            end
            if (!dspReq) begin
                dsp_armed_r <= 1'b1;
            end else if (dsp_ack_r) begin
                dsp_armed_r <= 1'b0;
            end else begin
                dsp_armed_r <= dsp_armed_r;
            end
        end
    end

    // Latch bank: cleared in IDLE on clrAll, loaded from holding regs in CAPTURE
    always_ff @(posedge MasterClock or negedge resetL) begin
        if (!resetL) begin
            for (int i = 0; i < ENTRIES; i++) begin
                entries_r[i] <= {WIDTH{1'b0}};
            end
        end else begin
            if ((state_r == ST_IDLE) && clrAll) begin
                for (int i = 0; i < ENTRIES; i++) begin
                    entries_r[i] <= {WIDTH{1'b0}};
                end
            end else if (state_r == ST_CAPTURE) begin
                entries_r[hold_addr_r] <= hold_data_r;
            end else begin
                for (int i = 0; i < ENTRIES; i++) begin
                    entries_r[i] <= entries_r[i];
                end
            end
        end
    end

    assign rdData = entries_r[rdAddr];
    assign busy   = busy_r;
    assign cpuAck = cpu_ack_r;
    assign dspAck = dsp_ack_r;

endmodule

// File: tb/tb_slip_latch_bank_arbiter.sv
// Directed, table-driven bench for slip_latch_bank_arbiter.
// Inputs change 1 time unit after each rising edge; outputs are sampled on
// the falling edge of the same cycle.
module tb_slip_latch_bank_arbiter;

    logic       MasterClock;
    logic       resetL;
    logic       clrAll;
    logic       cpuReq;
    logic [2:0] cpuAddr;
    logic [7:0] cpuData;
    logic       cpuAck;
    logic       dspReq;
    logic [2:0] dspAddr;
    logic [7:0] dspData;
    logic       dspAck;
    logic [2:0] rdAddr;
    logic [7:0] rdData;
    logic       busy;

    int n_vec;
    int n_mis;

    slip_latch_bank_arbiter #(.ENTRIES(8), .ADDR_W(3), .WIDTH(8)) dut (
        .MasterClock(MasterClock),
        .resetL     (resetL),
        .clrAll     (clrAll),
        .cpuReq     (cpuReq),
        .cpuAddr    (cpuAddr),
        .cpuData    (cpuData),
        .cpuAck     (cpuAck),
        .dspReq     (dspReq),
        .dspAddr    (dspAddr),
        .dspData    (dspData),
        .dspAck     (dspAck),
        .rdAddr     (rdAddr),
        .rdData     (rdData),
        .busy       (busy)
    );

    initial MasterClock = 1'b0;
    always #5 MasterClock = ~MasterClock;

    typedef struct {
        logic       clr;
        logic       cpu_req;
        logic [2:0] cpu_addr;
        logic [7:0] cpu_data;
        logic       dsp_req;
        logic [2:0] dsp_addr;
        logic [7:0] dsp_data;
        logic [2:0] rd_addr;
        logic       e_cpu_ack;
        logic       e_dsp_ack;
        logic       e_busy;
        logic [7:0] e_rd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic clr, logic cr, logic [2:0] ca, logic [7:0] cd,
                                logic dr, logic [2:0] da, logic [7:0] dd, logic [2:0] ra,
                                logic eca, logic eda, logic eb, logic [7:0] erd);
        vec_t v;
        v.clr = clr; v.cpu_req = cr; v.cpu_addr = ca; v.cpu_data = cd;
        v.dsp_req = dr; v.dsp_addr = da; v.dsp_data = dd; v.rd_addr = ra;
        v.e_cpu_ack = eca; v.e_dsp_ack = eda; v.e_busy = eb; v.e_rd = erd;
        return v;
    endfunction

    task automatic check(input string name, input logic eca, input logic eda,
                         input logic eb, input logic [7:0] erd);
        n_vec++;
        if (cpuAck !== eca || dspAck !== eda || busy !== eb || rdData !== erd) begin
            n_mis++;
            $display("FAIL %s: got cpuAck=%b dspAck=%b busy=%b rdData=%h, want cpuAck=%b dspAck=%b busy=%b rdData=%h",
                     name, cpuAck, dspAck, busy, rdData, eca, eda, eb, erd);
        end
    endtask

    initial begin
        n_vec = 0;
        n_mis = 0;
        resetL = 1'b0; clrAll = 1'b0;
        cpuReq = 1'b0; cpuAddr = 3'd0; cpuData = 8'h00;
        dspReq = 1'b0; dspAddr = 3'd0; dspData = 8'h00;
        rdAddr = 3'd0;

        // Tie after reset: lastGrant=DSP so CPU first, DSP granted at n+3
        tbl.push_back(mk(1'b0, 1'b1, 3'd1, 8'h11, 1'b1, 3'd1, 8'h22, 3'd1, 1'b0, 1'b0, 1'b0, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 3'd1, 8'h11, 1'b1, 3'd1, 8'h22, 3'd1, 1'b0, 1'b0, 1'b1, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 3'd1, 8'h11, 1'b1, 3'd1, 8'h22, 3'd1, 1'b1, 1'b0, 1'b1, 8'h11));
        tbl.push_back(mk(1'b0, 1'b0, 3'd1, 8'h11, 1'b1, 3'd1, 8'h22, 3'd1, 1'b0, 1'b0, 1'b0, 8'h11));
        tbl.push_back(mk(1'b0, 1'b0, 3'd1, 8'h11, 1'b1, 3'd1, 8'h22, 3'd1, 1'b0, 1'b0, 1'b1, 8'h11));
        tbl.push_back(mk(1'b0, 1'b0, 3'd1, 8'h11, 1'b1, 3'd1, 8'h22, 3'd1, 1'b0, 1'b1, 1'b1, 8'h22));
        tbl.push_back(mk(1'b0, 1'b0, 3'd1, 8'h11, 1'b0, 3'd1, 8'h22, 3'd1, 1'b0, 1'b0, 1'b0, 8'h22));
        // Single CPU write addr 3 = A5, req held to n+6 with no second ack
        tbl.push_back(mk(1'b0, 1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 8'h00, 3'd3, 1'b0, 1'b0, 1'b0, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 8'h00, 3'd3, 1'b0, 1'b0, 1'b1, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 8'h00, 3'd3, 1'b1, 1'b0, 1'b1, 8'hA5));
        tbl.push_back(mk(1'b0, 1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 8'h00, 3'd3, 1'b0, 1'b0, 1'b0, 8'hA5));
        tbl.push_back(mk(1'b0, 1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 8'h00, 3'd3, 1'b0, 1'b0, 1'b0, 8'hA5));
        tbl.push_back(mk(1'b0, 1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 8'h00, 3'd3, 1'b0, 1'b0, 1'b0, 8'hA5));
        tbl.push_back(mk(1'b0, 1'b1, 3'd3, 8'hA5, 1'b0, 3'd0, 8'h00, 3'd3, 1'b0, 1'b0, 1'b0, 8'hA5));
        tbl.push_back(mk(1'b0, 1'b0, 3'd3, 8'hA5, 1'b0, 3'd0, 8'h00, 3'd3, 1'b0, 1'b0, 1'b0, 8'hA5));
        // Re-armed tie: last winner was CPU, so DSP goes first
        tbl.push_back(mk(1'b0, 1'b1, 3'd5, 8'h5A, 1'b1, 3'd5, 8'h6B, 3'd5, 1'b0, 1'b0, 1'b0, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 3'd5, 8'h5A, 1'b1, 3'd5, 8'h6B, 3'd5, 1'b0, 1'b0, 1'b1, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 3'd5, 8'h5A, 1'b1, 3'd5, 8'h6B, 3'd5, 1'b0, 1'b1, 1'b1, 8'h6B));
        tbl.push_back(mk(1'b0, 1'b1, 3'd5, 8'h5A, 1'b0, 3'd5, 8'h6B, 3'd5, 1'b0, 1'b0, 1'b0, 8'h6B));
        tbl.push_back(mk(1'b0, 1'b1, 3'd5, 8'h5A, 1'b0, 3'd5, 8'h6B, 3'd5, 1'b0, 1'b0, 1'b1, 8'h6B));
        tbl.push_back(mk(1'b0, 1'b1, 3'd5, 8'h5A, 1'b0, 3'd5, 8'h6B, 3'd5, 1'b1, 1'b0, 1'b1, 8'h5A));
        tbl.push_back(mk(1'b0, 1'b0, 3'd5, 8'h5A, 1'b0, 3'd5, 8'h6B, 3'd5, 1'b0, 1'b0, 1'b0, 8'h5A));
        // Data changes after grant: holding register keeps 55
        tbl.push_back(mk(1'b0, 1'b1, 3'd0, 8'h55, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b1, 8'h00));
        tbl.push_back(mk(1'b0, 1'b1, 3'd0, 8'hFF, 1'b0, 3'd0, 8'h00, 3'd0, 1'b1, 1'b0, 1'b1, 8'h55));
        tbl.push_back(mk(1'b0, 1'b0, 3'd0, 8'hFF, 1'b0, 3'd0, 8'h00, 3'd0, 1'b0, 1'b0, 1'b0, 8'h55));
        // clrAll with DSP request: clear first, ack at n+3; clr in CAPTURE/ACK ignored
        tbl.push_back(mk(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 8'h3C, 3'd3, 1'b0, 1'b0, 1'b0, 8'hA5));
        tbl.push_back(mk(1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 8'h3C, 3'd3, 1'b0, 1'b0, 1'b0, 8'h00));
        tbl.push_back(mk(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 8'h3C, 3'd7, 1'b0, 1'b0, 1'b1, 8'h00));
        tbl.push_back(mk(1'b1, 1'b0, 3'd0, 8'h00, 1'b1, 3'd7, 8'h3C, 3'd7, 1'b0, 1'b1, 1'b1, 8'h3C));
        tbl.push_back(mk(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd7, 8'h3C, 3'd7, 1'b0, 1'b0, 1'b0, 8'h3C));
        tbl.push_back(mk(1'b0, 1'b0, 3'd0, 8'h00, 1'b0, 3'd7, 8'h3C, 3'd0, 1'b0, 1'b0, 1'b0, 8'h00));

        // Reset, then sweep the read port
        repeat (2) @(posedge MasterClock);
        #1 resetL = 1'b1;
        for (int a = 0; a < 8; a++) begin
            @(posedge MasterClock);
            #1 rdAddr = a[2:0];
            @(negedge MasterClock);
            check($sformatf("reset_sweep_%0d", a), 1'b0, 1'b0, 1'b0, 8'h00);
        end

        // Table vectors
        for (int i = 0; i < tbl.size(); i++) begin
            @(posedge MasterClock);
            #1;
            clrAll  = tbl[i].clr;
            cpuReq  = tbl[i].cpu_req;
            cpuAddr = tbl[i].cpu_addr;
            cpuData = tbl[i].cpu_data;
            dspReq  = tbl[i].dsp_req;
            dspAddr = tbl[i].dsp_addr;
            dspData = tbl[i].dsp_data;
            rdAddr  = tbl[i].rd_addr;
            @(negedge MasterClock);
            check($sformatf("vec_%0d", i), tbl[i].e_cpu_ack, tbl[i].e_dsp_ack,
                  tbl[i].e_busy, tbl[i].e_rd);
        end

        // Reset mid-write: 0x99 to entry 4 aborted during CAPTURE
        @(posedge MasterClock);
        #1 clrAll = 1'b0; cpuReq = 1'b1; cpuAddr = 3'd4; cpuData = 8'h99; rdAddr = 3'd4;
        @(negedge MasterClock);
        check("rst_mid_grant", 1'b0, 1'b0, 1'b0, 8'h00);
        @(posedge MasterClock);
        #1 resetL = 1'b0;
        @(negedge MasterClock);
        check("rst_mid_held", 1'b0, 1'b0, 1'b0, 8'h00);
        @(posedge MasterClock);
        #1 cpuReq = 1'b0; resetL = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge MasterClock);
            check($sformatf("rst_mid_after_%0d", k), 1'b0, 1'b0, 1'b0, 8'h00);
            @(posedge MasterClock);
            #1;
        end
        cpuReq = 1'b1; cpuAddr = 3'd4; cpuData = 8'h77;
        @(negedge MasterClock);
        check("post_rst_n", 1'b0, 1'b0, 1'b0, 8'h00);
        @(posedge MasterClock);
        @(negedge MasterClock);
        check("post_rst_n1", 1'b0, 1'b0, 1'b1, 8'h00);
        @(posedge MasterClock);
        @(negedge MasterClock);
        check("post_rst_n2", 1'b1, 1'b0, 1'b1, 8'h77);
        @(posedge MasterClock);
        #1 cpuReq = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
